// File: rtl/mux_array_seq_pkg.sv
// rtl/mux_array_seq_pkg.sv - shared sizing helpers and state encoding for mux_array_seq
package mux_array_seq_pkg;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // A single group still needs a one-bit index port.
   function automatic int group_width(input int num_group);
      return (clog2(num_group) < 1) ? 1 : clog2(num_group);
   endfunction

endpackage

// File: rtl/mux_array_seq_slice.sv
// rtl/mux_array_seq_slice.sv - group_slice_mux: picks one Pin-lane group from a word, zero-padding past Nin (mask with MUX_ARRAY_SEQ_MASK_EN)
module group_slice_mux
   import mux_array_seq_pkg::*;
#(
   parameter int Nin       = 3,
   parameter int Pin       = 2,
   parameter int BIT_WIDTH = 8,
   localparam int NUM_GROUP = ceil_div(Nin, Pin),
   localparam int GW        = group_width(NUM_GROUP)
) (
   input  logic [Nin*BIT_WIDTH-1:0] word,
   input  logic [GW-1:0]            group,
   output logic [Pin*BIT_WIDTH-1:0] slice
`ifdef MUX_ARRAY_SEQ_MASK_EN
   ,
   output logic [Pin-1:0]           mask
`endif
);

   logic [NUM_GROUP-1:0][Pin*BIT_WIDTH-1:0] group_word;
`ifdef MUX_ARRAY_SEQ_MASK_EN
   logic [NUM_GROUP-1:0][Pin-1:0]           group_mask;
`endif

   // Static wiring of every group; lanes beyond the last channel tie to zero.
   for (genvar g = 0; g < NUM_GROUP; g++) begin : g_grp
      for (genvar i = 0; i < Pin; i++) begin : g_lane
         if (i + g*Pin < Nin) begin : g_real
            assign group_word[g][i*BIT_WIDTH +: BIT_WIDTH] = word[(i + g*Pin)*BIT_WIDTH +: BIT_WIDTH];
`ifdef MUX_ARRAY_SEQ_MASK_EN
            assign group_mask[g][i] = 1'b1;
`endif
         end else begin : g_pad
            assign group_word[g][i*BIT_WIDTH +: BIT_WIDTH] = '0;
`ifdef MUX_ARRAY_SEQ_MASK_EN
            assign group_mask[g][i] = 1'b0;
`endif
         end
      end
   end

   always_comb begin
      slice = '0;
`ifdef MUX_ARRAY_SEQ_MASK_EN
      mask  = '0;
`endif
      for (int g = 0; g < NUM_GROUP; g++) begin
         if (group == GW'(g)) begin
            slice = group_word[g];
`ifdef MUX_ARRAY_SEQ_MASK_EN
            mask  = group_mask[g];
`endif
         end
      end
   end

endmodule

// File: rtl/mux_array_seq.sv
// rtl/mux_array_seq.sv - streaming channel-group serializer: one Nin-channel word in, NUM_GROUP Pin-lane beats out
// optional out_mask port enabled by MUX_ARRAY_SEQ_MASK_EN
module mux_array_seq
   import mux_array_seq_pkg::*;
#(
   parameter int Nin       = 3,
   parameter int Pin       = 2,
   parameter int BIT_WIDTH = 8,
   localparam int NUM_GROUP = ceil_div(Nin, Pin),
   localparam int GW        = group_width(NUM_GROUP)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [Nin*BIT_WIDTH-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [Pin*BIT_WIDTH-1:0] out_data,
   output logic [GW-1:0]            out_group,
   output logic                     out_last
`ifdef MUX_ARRAY_SEQ_MASK_EN
   ,
   output logic [Pin-1:0]           out_mask
`endif
);

   logic [0:0]               state_q;
   logic [GW-1:0]            grp_q;
   logic [Nin*BIT_WIDTH-1:0] hold_q;
   logic                     in_acc;
   logic                     out_acc;
   logic                     at_last;
   logic [GW-1:0]            grp_next;
   logic [Nin*BIT_WIDTH-1:0] sel_word;
   logic [GW-1:0]            sel_group;
   logic [Pin*BIT_WIDTH-1:0] sel_slice;
`ifdef MUX_ARRAY_SEQ_MASK_EN
   logic [Pin-1:0]           sel_mask;
`endif

   assign at_last   = (grp_q == GW'(NUM_GROUP - 1));
   assign grp_next  = grp_q + GW'(1);
   assign in_ready  = rst_n & ~flush & ((state_q == ST_IDLE) | (out_last & out_ready));
   assign in_acc    = in_valid & in_ready;
   assign out_acc   = out_valid & out_ready;
   assign out_group = grp_q;

   // A fresh word always starts at group 0; otherwise advance through the held word.
   assign sel_word  = in_acc ? in_data : hold_q;
   assign sel_group = in_acc ? '0 : grp_next;

   group_slice_mux #(
      .Nin       (Nin),
      .Pin       (Pin),
      .BIT_WIDTH (BIT_WIDTH)
   ) u_slice (
      .word  (sel_word),
      .group (sel_group),
      .slice (sel_slice)
`ifdef MUX_ARRAY_SEQ_MASK_EN
      ,
      .mask  (sel_mask)
`endif
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         grp_q     <= '0;
         hold_q    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
`ifdef MUX_ARRAY_SEQ_MASK_EN
         out_mask  <= '0;
`endif
      end else if (flush) begin
         state_q   <= ST_IDLE;
         grp_q     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
`ifdef MUX_ARRAY_SEQ_MASK_EN
         out_mask  <= '0;
`endif
      end else if (in_acc) begin
         // Covers both the idle start and the bubble-free reload on the last beat.
         state_q   <= ST_SEND;
         hold_q    <= in_data;
         grp_q     <= '0;
         out_valid <= 1'b1;
         out_data  <= sel_slice;
         out_last  <= (NUM_GROUP == 1);
`ifdef MUX_ARRAY_SEQ_MASK_EN
         out_mask  <= sel_mask;
`endif
      end else if (out_acc) begin
         if (!at_last) begin
            grp_q    <= grp_next;
            out_data <= sel_slice;
            out_last <= (grp_next == GW'(NUM_GROUP - 1));
`ifdef MUX_ARRAY_SEQ_MASK_EN
            out_mask <= sel_mask;
`endif
         end else begin
            state_q   <= ST_IDLE;
            grp_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
`ifdef MUX_ARRAY_SEQ_MASK_EN
            out_mask  <= '0;
`endif
         end
      end
   end

endmodule
